// File: rtl/operand_shift_loader.sv
// operand_shift_loader
// Collects LANES serial bit streams (MSB first) into WIDTH-bit operands,
// frames them with a shared bit counter and presents each completed operand
// set through a registered valid/ready output stage. A sticky overrun flag
// records any completed frame dropped because the output slot was occupied.
module operand_shift_loader #(
  parameter int WIDTH = 32,
  parameter int LANES = 3,
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       serial_data,
  input  logic                   serial_en,
  input  logic                   frame_start,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] operands,
  output logic                   out_valid,
  output logic                   overrun,
  output logic [CW-1:0]          bit_count
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Per-lane shift registers and the value each lane holds after this cycle's shift
  logic [WIDTH-1:0]       sr_reg [LANES];
  logic [LANES*WIDTH-1:0] shifted_next;

  // A frame completes only on a plain shift of its last bit; a resync never completes
  logic complete;
  logic slot_free;

  assign complete  = serial_en && !frame_start && (bit_count == LAST_BIT);
  assign slot_free = !out_valid || out_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign shifted_next[gi*WIDTH +: WIDTH] = {sr_reg[gi][WIDTH-2:0], serial_data[gi]};

      // Shift one bit into this lane on every strobe (also on the first bit of a resync)
      always_ff @(posedge clk) begin
        if (reset) begin
          sr_reg[gi] <= '0;
        end else if (serial_en) begin
          sr_reg[gi] <= shifted_next[gi*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  // Frame bit counter: resync restarts the count, otherwise wrap at the last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= '0;
    end else if (frame_start) begin
      bit_count <= serial_en ? CW'(1) : '0;
    end else if (serial_en) begin
      bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + CW'(1);
    end
  end

  // Output slot: load on completion when free, drop and flag when occupied, release on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      operands  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete && slot_free) begin
      operands  <= shifted_next;
      out_valid <= 1'b1;
    end else if (complete) begin
      overrun   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_shift_loader.sv
// Testbench for operand_shift_loader: scoreboard of expected operand sets,
// pushed when a frame's last bit is driven and popped on each accepted handshake.
module tb_operand_shift_loader;

  localparam int WIDTH = 32;
  localparam int LANES = 3;
  localparam int CW    = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LANES-1:0]       serial_data;
  logic                   serial_en;
  logic                   frame_start;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] operands;
  logic                   out_valid;
  logic                   overrun;
  logic [CW-1:0]          bit_count;

  operand_shift_loader #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .serial_data(serial_data), .serial_en(serial_en),
    .frame_start(frame_start), .out_ready(out_ready), .operands(operands),
    .out_valid(out_valid), .overrun(overrun), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fs_cyc = 0;
  logic [95:0] sb [$];
  int hs_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Monitor: every accepted operand set is compared against the oldest expected set
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check_val("sb_avail", 96'(sb.size() > 0), 96'(1));
      if (sb.size() > 0) check_val("handshake_operands", operands, sb.pop_front());
      hs_cyc.push_back(cyc);
    end
  end

  // Drive one full frame MSB-first; optionally resync on its first bit and expect its completion
  task automatic send_frame(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                            input bit fs, input bit push);
    for (int b = WIDTH - 1; b >= 0; b--) begin
      serial_data = {l2[b], l1[b], l0[b]};
      serial_en   = 1'b1;
      frame_start = fs && (b == WIDTH - 1);
      if (push && b == 0) sb.push_back({l2, l1, l0});
      @(posedge clk); #1;
      if (fs && b == WIDTH - 1) begin
        fs_cyc = cyc;
        check_val("fs_bit_count", 96'(bit_count), 96'(1));
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    serial_en = 1'b0;
    frame_start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1; serial_data = '0; serial_en = 1'b0; frame_start = 1'b0; out_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_operands", operands, 96'h0);
    check_val("rst_valid", 96'(out_valid), 96'(0));
    check_val("rst_overrun", 96'(overrun), 96'(0));
    check_val("rst_bit_count", 96'(bit_count), 96'(0));
    idle(4);
    check_val("idle_valid", 96'(out_valid), 96'(0));
    check_val("idle_bit_count", 96'(bit_count), 96'(0));

    // Single frame, held with out_ready low
    send_frame(32'hDEADBEEF, 32'h12345678, 32'h00000001, 1'b1, 1'b1);
    serial_en = 1'b0;
    check_val("single_valid", 96'(out_valid), 96'(1));
    check_val("single_operands", operands, {32'h00000001, 32'h12345678, 32'hDEADBEEF});
    idle(3);
    check_val("hold_valid", 96'(out_valid), 96'(1));
    check_val("hold_operands", operands, {32'h00000001, 32'h12345678, 32'hDEADBEEF});

    // Overrun: second frame while the slot is still occupied
    send_frame(32'hCAFEF00D, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    serial_en = 1'b0;
    check_val("ovr_flag", 96'(overrun), 96'(1));
    check_val("ovr_lane0", 96'(operands[31:0]), 96'(32'hDEADBEEF));
    check_val("ovr_valid", 96'(out_valid), 96'(1));

    // Single accept cycle drains the held set
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("accept_valid", 96'(out_valid), 96'(0));
    check_val("accept_overrun_sticky", 96'(overrun), 96'(1));

    // Streaming: three back-to-back frames, consumer always ready
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hs_cyc.delete();
    out_ready = 1'b1;
    send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000001, 1'b0, 1'b1);
    send_frame(32'h13579BDF, 32'h2468ACE0, 32'hFFFF0000, 1'b0, 1'b1);
    send_frame(32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFE, 1'b0, 1'b1);
    idle(2);
    check_val("stream_count", 96'(hs_cyc.size()), 96'(3));
    if (hs_cyc.size() == 3) begin
      check_val("stream_gap1", 96'(hs_cyc[1] - hs_cyc[0]), 96'(32));
      check_val("stream_gap2", 96'(hs_cyc[2] - hs_cyc[1]), 96'(32));
    end
    check_val("stream_overrun", 96'(overrun), 96'(0));

    // Resync after 10 bits: completion 31 strobes after the frame_start edge
    hs_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      serial_data = 3'($urandom);
      serial_en = 1'b1;
      @(posedge clk); #1;
    end
    check_val("pre_resync_count", 96'(bit_count), 96'(10));
    send_frame(32'h89ABCDEF, 32'h01234567, 32'hF0E1D2C3, 1'b1, 1'b1);
    idle(2);
    check_val("resync_count", 96'(hs_cyc.size()), 96'(1));
    if (hs_cyc.size() > 0) check_val("resync_latency", 96'(hs_cyc[0] - fs_cyc), 96'(31));

    // Reset mid-frame while a set is pending
    out_ready = 1'b0;
    send_frame(32'h55555555, 32'h66666666, 32'h77777777, 1'b0, 1'b0);
    for (int b = 0; b < 17; b++) begin
      serial_data = 3'($urandom);
      serial_en = 1'b1;
      @(posedge clk); #1;
    end
    serial_en = 1'b0;
    check_val("mid_bit_count", 96'(bit_count), 96'(17));
    check_val("mid_valid", 96'(out_valid), 96'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("mrst_operands", operands, 96'h0);
    check_val("mrst_valid", 96'(out_valid), 96'(0));
    check_val("mrst_bit_count", 96'(bit_count), 96'(0));
    send_frame(32'h0BADCAFE, 32'hFEEDFACE, 32'h00C0FFEE, 1'b0, 1'b1);
    serial_en = 1'b0;
    check_val("post_valid", 96'(out_valid), 96'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle(2);
    check_val("sb_drained", 96'(sb.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
